// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between a CPU request port and a combinational-read data memory.
// Sub-word stores are done as a word read-modify-write; misaligned or illegal requests answer with an error.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wr_data,
    output logic        dm_mem_wr,
    output logic        dm_mem_rd,
    output logic [2:0]  dm_mask,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // BU/HU exist only as loads, so they are errors when paired with a store.
    function automatic logic req_is_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic err;
        err = 1'b0;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = a[0];
            F3_W:    err = (a != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | a[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] m;
        m = word;
        case (f3)
            F3_B:    m[{a, 3'b000} +: 8] = wd[7:0];
            F3_H:    m[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;
    logic [31:0] r_rsp_rdata;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic        w_accept;
    logic        w_req_err;
    logic [31:0] w_word_addr;

    assign req_ready   = (r_state == ST_IDLE);
    assign w_accept    = req_valid & req_ready;
    assign w_req_err   = req_is_err(req_we, req_funct3, req_addr[1:0]);
    assign w_word_addr = {r_addr[31:2], 2'b00};
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_accept) begin
                    w_next = ST_IDLE;
                end else if (w_req_err) begin
                    w_next = ST_RESP;
                end else if (!req_we) begin
                    w_next = ST_LOAD;
                end else if (req_funct3 == F3_W) begin
                    w_next = ST_WRITE;
                end else begin
                    w_next = ST_RMW_RD;
                end
            end
            ST_LOAD:   w_next = ST_RESP;
            ST_RMW_RD: w_next = ST_WRITE;
            ST_WRITE:  w_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    // Data-memory port decode; everything is zero outside the three access states
    always_comb begin
        dm_addr    = 32'h0000_0000;
        dm_wr_data = 32'h0000_0000;
        dm_mem_wr  = 1'b0;
        dm_mem_rd  = 1'b0;
        dm_mask    = 3'b000;
        case (r_state)
            ST_LOAD: begin
                dm_mem_rd = 1'b1;
                dm_mask   = r_funct3;
                dm_addr   = r_addr;
            end
            ST_RMW_RD: begin
                dm_mem_rd = 1'b1;
                dm_mask   = F3_W;
                dm_addr   = w_word_addr;
            end
            ST_WRITE: begin
                dm_mem_wr  = r_we;
                dm_mask    = F3_W;
                dm_addr    = w_word_addr;
                dm_wr_data = (r_funct3 == F3_W) ? r_wdata : r_merged;
            end
            default: begin
                dm_mem_wr = 1'b0;
                dm_mem_rd = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch and read-modify-write merge buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= 32'h0000_0000;
            r_wdata  <= 32'h0000_0000;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_merged <= 32'h0000_0000;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_we     <= req_we;
                r_funct3 <= req_funct3;
            end
            if (r_state == ST_RMW_RD) begin
                r_merged <= merge_word(dm_rdata, r_wdata, r_funct3, r_addr[1:0]);
            end
        end
    end

    // Response registers; data is cleared at acceptance so stores and errors answer with zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end else begin
            r_rsp_valid <= (w_next == ST_RESP);
            if (w_accept) begin
                r_rsp_err   <= w_req_err;
                r_rsp_rdata <= 32'h0000_0000;
            end else if (r_state == ST_LOAD) begin
                r_rsp_rdata <= dm_rdata;
            end
        end
    end

endmodule
